// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Bundles the execute-stage side of the multi-cycle divider.
//   startE    : DIV/DIVU held in the execute stage (level)
//   signedE   : 1 = DIV (signed), 0 = DIVU
//   a, b      : dividend / divisor, sampled when a start is accepted
//   cancel    : flush / exception, aborts any operation in progress
//   stall_div : hold the pipeline at E and earlier stages
//   ready     : one-cycle pulse, hi/lo valid this cycle
//   hi, lo    : remainder / quotient
// The master modport is the pipeline, the slave modport is the divider.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             stall_div;
    logic             ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, signedE, a, b, cancel,
        input  stall_div, ready, hi, lo
    );

    modport slave (
        input  startE, signedE, a, b, cancel,
        output stall_div, ready, hi, lo
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
// Radix-2 restoring divider for the HI/LO path. One quotient bit per
// cycle; the pipeline is stalled while a division is in flight. On
// completion the remainder is presented on hi and the quotient on lo
// for one ready cycle, and both hold until the next completion.
// Ports:
//   clk : pipeline clock
//   rst : synchronous, active-high reset
//   bus : div_sequencer_if.slave (startE, signedE, a, b, cancel in;
//         stall_div, ready, hi, lo out)
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    div_sequencer_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negation; wraps for the most negative value.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   rem_sh_s;         // {remainder, next dividend bit}
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic             a_neg_s;
    logic             b_neg_s;

    // One restoring step: shift, trial-subtract, keep result if non-negative.
    always_comb begin
        rem_sh_s = {rem_q, quo_q[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dvs_q};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_step_s = trial_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = rem_sh_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand signs only matter for DIV.
    always_comb begin
        a_neg_s = bus.signedE & bus.a[WIDTH-1];
        b_neg_s = bus.signedE & bus.b[WIDTH-1];
    end

    // Next-state and datapath update; cancel overrides start and completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (bus.cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.startE) begin
                        if (bus.b == {WIDTH{1'b0}}) begin
                            lo_d    = {WIDTH{1'b1}};
                            hi_d    = bus.a;
                            state_d = S_DONE;
                        end else begin
                            neg_quo_d = a_neg_s ^ b_neg_s;
                            neg_rem_d = a_neg_s;
                            quo_d     = a_neg_s ? neg_f(bus.a) : bus.a;
                            dvs_d     = b_neg_s ? neg_f(bus.b) : bus.b;
                            rem_d     = {WIDTH{1'b0}};
                            cnt_d     = {CW{1'b0}};
                            state_d   = S_RUN;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_d = rem_step_s;
                    quo_d = quo_step_s;
                    if (cnt_q == LAST_ITER) begin
                        // Sign fix-up folded into the final iteration.
                        lo_d    = neg_quo_q ? neg_f(quo_step_s) : quo_step_s;
                        hi_d    = neg_rem_q ? neg_f(rem_step_s) : rem_step_s;
                        cnt_d   = {CW{1'b0}};
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    // startE here still belongs to the finishing instruction.
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Stall and ready must react in the same cycle as cancel/reset, so they
    // are gated combinationally on top of the registered state.
    always_comb begin
        bus.stall_div = ~rst & bus.startE & ~bus.cancel & (state_q != S_DONE);
        bus.ready     = ~rst & ~bus.cancel & (state_q == S_DONE);
        bus.hi        = hi_q;
        bus.lo        = lo_q;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer: unsigned/signed division, divide
// by zero, cancel mid-run, back-to-back divides and reset mid-run.
module tb_div_sequencer;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one divide starting at the current cycle (called at posedge+1
    // with the DUT in IDLE). Operands are scrambled after cycle 0.
    task automatic do_div(input string tag, input logic sgn,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_cyc, input bit keep_start, input bit chk_zero);
        int stalls = 0;
        int rdy_at = -1;
        bus.startE  = 1'b1;
        bus.signedE = sgn;
        bus.a       = av;
        bus.b       = bv;
        for (int c = 0; c < 60 && rdy_at < 0; c++) begin
            @(negedge clk);
            if (c == 0 && chk_zero) begin
                check({tag, " hi_after_rst"}, bus.hi, 32'h0);
                check({tag, " lo_after_rst"}, bus.lo, 32'h0);
            end
            if (bus.ready === 1'b1) begin
                rdy_at = c;
                check({tag, " stall_in_done"}, 32'(bus.stall_div), 32'h0);
                check({tag, " lo"}, bus.lo, exp_lo);
                check({tag, " hi"}, bus.hi, exp_hi);
            end else if (bus.stall_div === 1'b1) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.a       = 32'hDEAD_BEEF;
                bus.b       = 32'h1234_5678;
                bus.signedE = ~sgn;
            end
        end
        check({tag, " ready_cycle"}, 32'(rdy_at), 32'(exp_cyc));
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_cyc));
        if (!keep_start) bus.startE = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.a       = 32'd9;
        bus.b       = 32'd3;
        bus.cancel  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset ready", 32'(bus.ready), 32'h0);
        check("reset stall_forced_low", 32'(bus.stall_div), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 1'b0);
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0, 1'b0);
        do_div("div0 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1'b0, 1'b0);
        do_div("divu 100/7 again", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 1'b0);

        // Cancel at cycle 10 of a run.
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.a       = 32'd500;
        bus.b       = 32'd9;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel stall", 32'(bus.stall_div), 32'h0);
        check("cancel ready", 32'(bus.ready), 32'h0);
        check("cancel hi_held", bus.hi, 32'd2);
        check("cancel lo_held", bus.lo, 32'd14);
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        // Starting immediately proves the FSM returned to IDLE.
        do_div("after cancel 1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b0, 1'b0);

        // Back-to-back: signed overflow wrap, then DIVU.
        do_div("div 80000000/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, 1'b1, 1'b0);
        do_div("divu ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 1'b1, 1'b0);

        // Reset at cycle 20 of a run with startE held high.
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst stall", 32'(bus.stall_div), 32'h0);
        check("rst ready", 32'(bus.ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_div("post-reset 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divider and sequencer for the MIPS pipeline's HI/LO path. It executes DIV/DIVU issued from the execute stage with radix-2 restoring division, one quotient bit per cycle. While a division is in flight it stalls the pipeline. When the division finishes it presents the remainder on `hi` and the quotient on `lo` for the HI/LO register write (`hilowriteE` path).

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits.

Ports:
- `clk`  in  1  pipeline clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `startE`  in  1  a DIV/DIVU instruction is in the execute stage. This is a level signal that stays high while the instruction is held there.
- `signedE`  in  1  1 = DIV (signed), 0 = DIVU. Sampled only when a start is accepted.
- `a`  in  WIDTH  dividend (rs value). Sampled only when a start is accepted.
- `b`  in  WIDTH  divisor (rt value). Sampled only when a start is accepted.
- `cancel`  in  1  flushE/exception. Aborts any operation in progress.
- `stall_div`  out  1  hold the pipeline at E and earlier stages.
- `ready`  out  1  one-cycle pulse: `hi`/`lo` are valid this cycle.
- `hi`  out  WIDTH  remainder (registered).
- `lo`  out  WIDTH  quotient (registered).

## Operation
FSM states: IDLE, RUN, DONE.

IDLE:
- If `startE & ~cancel` and `b == 0`, go to DONE and load `lo = {WIDTH{1'b1}}`, `hi = a`.
- Else if `startE & ~cancel`, latch the sign flags and the absolute values of `a`/`b`, clear the partial remainder, set the iteration counter to 0, and go to RUN.
- Absolute values are taken only when `signedE = 1`. For DIVU the operands are used as-is.

RUN, each cycle:
- Shift {remainder, dividend} left by 1.
- Trial-subtract the divisor from the remainder, using a WIDTH+1-bit subtract.
- If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
- Increment the counter. After the WIDTH-th iteration (counter = WIDTH-1), go to DONE.

Entering DONE from RUN:
- Apply the sign fix-up: negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
- Two's-complement wrap is intentional: signed 0x80000000 / 0xFFFFFFFF gives `lo = 0x80000000`, `hi = 0`.
- Register the results into `hi`/`lo`.

DONE: `ready = 1` for exactly one cycle, then go to IDLE unconditionally. `startE` in DONE does not restart, because it still belongs to the finishing instruction.

`stall_div = startE & ~cancel & (state != DONE)`, computed combinationally. It is forced to 0 while `rst` is high.

`cancel` in any state:
- Next state is IDLE.
- `ready` stays 0 in the cycle `cancel` is high and in the cycle that follows.
- `hi`/`lo` are not updated.
- `cancel` takes priority over start and over completion.

`hi`/`lo` hold their values until the next DONE load. Nothing else modifies them.

Reset: state IDLE, counter 0, `hi = 0`, `lo = 0`, `ready = 0`, `stall_div = 0`.

## Timing
- Let cycle 0 be the IDLE cycle in which a start is accepted (b ≠ 0).
  - RUN occupies cycles 1..WIDTH.
  - DONE is at cycle WIDTH+1 (33 for the default).
  - `stall_div` is high in cycles 0..WIDTH (33 cycles) and low in cycle WIDTH+1.
  - `ready` is high in cycle WIDTH+1.
  - The pipeline advances on the clock edge that ends the DONE cycle; the HI/LO write is captured from `hi`/`lo` then.
- Divide-by-zero: DONE is at cycle 1, so `stall_div` is high for 1 cycle and `ready` is high at cycle 1.
- Back-to-back divides: if the next instruction is also a divide, its `startE` is seen in IDLE at cycle WIDTH+2 and its stall begins there. There are no bubble cycles beyond the normal FSM timing.
- Reset asserted mid-RUN: next cycle is IDLE with all outputs at reset values. No partial results become visible.
- Operands may change after cycle 0 without affecting the result.

## Test plan
- Unsigned 100 / 7: `startE = 1`, `signedE = 0` -> `stall_div` high 33 cycles, `ready` at cycle 33, `lo = 14`, `hi = 2`.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`. Also signed 7 / -2 -> `lo = 0xFFFFFFFD`, `hi = 1`.
- Divide-by-zero, a = 5, b = 0 -> `ready` at cycle 1, `lo = 0xFFFFFFFF`, `hi = 5`, `stall_div` high for cycle 0 only.
- `cancel` asserted at cycle 10 of a run (previous `hi`/`lo` = 2/14) -> IDLE next cycle, `ready` never pulses, `hi`/`lo` remain 2/14, `stall_div` low in the cancel cycle.
- Signed 0x80000000 / 0xFFFFFFFF followed immediately by DIVU 0xFFFFFFFF / 0x10:
  - First result: `lo = 0x80000000`, `hi = 0`, at cycle 33.
  - Second divide starts at cycle 34; its result (`lo = 0x0FFFFFFF`, `hi = 0xF`) arrives at cycle 67.
- `rst` pulsed at cycle 20 of a run -> next cycle IDLE, `hi = lo = 0`, `ready = 0`, `stall_div = 0`. With `startE` still high after reset, a fresh division starts and completes 33 cycles later.
